fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry instruction queue between Fetch and Decode.
- Carries {instr, pc, pc+4} per entry with per-entry valid, decode-side stall, and synchronous flush.
- Lets Fetch run ahead of a stalled Decode. On an empty queue it presents a NOP bubble to Decode.

Parameters:
- XLEN, 32, width of the instr, pc and pc+4 fields.
- DEPTH, 4, number of queue entries; a power of two, ≥2.
- NOP_INSTR, 32'h0000_0013, instruction word driven on instr_d when the queue is empty.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- push_valid  in  1  Fetch presents a valid instruction.
- push_ready  out  1  queue can accept (count != DEPTH).
- instr_f  in  XLEN  fetched instruction word.
- pc_f  in  XLEN  PC of the fetched instruction.
- pcplus4_f  in  XLEN  PC+4 of the fetched instruction.
- stall_d  in  1  Decode holds its current instruction (no pop).
- flush_d  in  1  discard all queued entries (branch/jump redirect).
- valid_d  out  1  head entry is valid.
- instr_d  out  XLEN  head instruction, or NOP_INSTR when empty.
- pc_d  out  XLEN  head PC, or 0 when empty.
- pcplus4_d  out  XLEN  head PC+4, or 0 when empty.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer with wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap) and a count register.
- Reset (async) clears wr_ptr, rd_ptr and count. Outputs are then: valid_d=0, instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0, push_ready=1, count=0.
- Storage array contents need no reset.
- Push: push_valid && push_ready. The entry is written at wr_ptr and wr_ptr increments.
- Pop: valid_d && !stall_d. rd_ptr increments.
- push_ready = (count != DEPTH). It has no combinational dependence on stall_d, so a full queue rejects a push even in a cycle that also pops.
- Outputs are a mux of registered state only (head entry, or bubble when count==0). There is no combinational path from any input to any output.
- Latency: an instruction pushed into an empty queue at edge N appears on the *_d outputs after edge N. This is the same 1-cycle latency as a plain pipeline register.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Push only: count+1. Pop only: count-1. Neither: all state held.
- stall_d with count==0: no effect. valid_d stays 0.
- flush_d has the highest priority. At the edge it sets wr_ptr=rd_ptr=0 and count=0, and any push or pop in that cycle is discarded. The next cycle shows the bubble; push_ready=1.
- flush_d and reset together: reset wins (async). The result is identical either way.
- Pointer wrap: after DEPTH pushes the pointers wrap to 0. FIFO order is preserved across the wrap.
- Dropping push_valid while push_ready=0 has no effect; Fetch must hold its PC itself.

Optional Feature:
- Macro FDQ_PERF_EN.
- When defined, two extra outputs are added:
  - stall_full_cnt [31:0]: increments each cycle that push_valid && !push_ready.
  - flush_cnt [31:0]: increments on each cycle with flush_d=1.
- Both counters reset to 0 on reset, are not cleared by flush_d, and wrap at 2^32.
- When undefined, neither port nor logic exists and behaviour is otherwise identical.

Test Plan:
- Reset then idle → valid_d=0, instr_d=32'h00000013, pc_d=0, push_ready=1, count=0 for 5 cycles.
- Push instr 32'h00A00093 with pc 0x100 and pc+4 0x104, stall_d=0 → next cycle valid_d=1, instr_d=32'h00A00093, pc_d=0x100, pcplus4_d=0x104. The cycle after that shows the bubble.
- stall_d=1 while pushing pc 0x0,0x4,0x8,0xC,0x10 on consecutive cycles:
  - count reaches 4 and push_ready=0; the 0x10 push is rejected and pc_d stays 0x0.
  - Release stall_d → pc_d sequence 0x0,0x4,0x8,0xC, then bubble.
- Continuous push and pop for 10 cycles (pc 0x0..0x24) → count stays 1, pc_d follows inputs with 1-cycle lag, pointers wrap correctly.
- With count=3, assert flush_d together with push_valid (pc 0x200) → next cycle count=0, valid_d=0, instr_d=NOP_INSTR; the 0x200 entry is never presented.
- Assert reset asynchronously mid-cycle with count=2 → outputs go to the bubble and count=0 immediately, before the next clk edge. With FDQ_PERF_EN defined, both counters also read 0.

Source files
------------

// File: rtl/fetch_decode_queue_if.sv
// Fetch/Decode handshake bundle for the instruction queue.
// The master modport is the Fetch/Decode side; the slave modport is the queue.
interface fetch_decode_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            push_valid;
  logic            push_ready;
  logic [XLEN-1:0] instr_f;
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pcplus4_f;
  logic            stall_d;
  logic            flush_d;
  logic            valid_d;
  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pcplus4_d;
  logic [CW-1:0]   count;

  modport master (
    output push_valid, instr_f, pc_f, pcplus4_f, stall_d, flush_d,
    input  push_ready, valid_d, instr_d, pc_d, pcplus4_d, count
  );

  modport slave (
    input  push_valid, instr_f, pc_f, pcplus4_f, stall_d, flush_d,
    output push_ready, valid_d, instr_d, pc_d, pcplus4_d, count
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// DEPTH-entry IF/ID instruction queue carrying {instr, pc, pc+4}; NOP bubble when empty.
// Optional FDQ_PERF_EN adds stall_full_cnt and flush_cnt performance counters.
module fetch_decode_queue #(
  parameter int unsigned    XLEN      = 32,
  parameter int unsigned    DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_decode_queue_if.slave  bus
`ifdef FDQ_PERF_EN
  ,
  output logic [31:0]          stall_full_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic   push_ready_c;
  logic   valid_c;
  logic   push_c;
  logic   pop_c;
  entry_t head_c;

  // Handshake qualifiers depend only on registered occupancy and the inputs.
  assign push_ready_c = (count_q != CW'(DEPTH));
  assign valid_c      = (count_q != CW'(0));
  assign push_c       = bus.push_valid && push_ready_c;
  assign pop_c        = valid_c && !bus.stall_d;
  assign head_c       = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush_d) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_c && !pop_c)      count_d = count_q + CW'(1);
      else if (pop_c && !push_c) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is left unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_c && !bus.flush_d) begin
      mem_q[wr_ptr_q] <= '{instr: bus.instr_f, pc: bus.pc_f, pcplus4: bus.pcplus4_f};
    end
  end

  assign bus.push_ready = push_ready_c;
  assign bus.valid_d    = valid_c;
  assign bus.instr_d    = valid_c ? head_c.instr   : NOP_INSTR;
  assign bus.pc_d       = valid_c ? head_c.pc      : '0;
  assign bus.pcplus4_d  = valid_c ? head_c.pcplus4 : '0;
  assign bus.count      = count_q;

`ifdef FDQ_PERF_EN
  logic [31:0] stall_full_cnt_q, stall_full_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Counters survive flushes and wrap naturally.
  always_comb begin
    stall_full_cnt_d = stall_full_cnt_q;
    flush_cnt_d      = flush_cnt_q;
    if (bus.push_valid && !push_ready_c) stall_full_cnt_d = stall_full_cnt_q + 32'd1;
    if (bus.flush_d)                     flush_cnt_d      = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_full_cnt_q <= '0;
      flush_cnt_q      <= '0;
    end else begin
      stall_full_cnt_q <= stall_full_cnt_d;
      flush_cnt_q      <= flush_cnt_d;
    end
  end

  assign stall_full_cnt = stall_full_cnt_q;
  assign flush_cnt      = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed, table-driven bench for fetch_decode_queue (DEPTH=4, XLEN=32).
module tb_fetch_decode_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  fetch_decode_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

`ifdef FDQ_PERF_EN
  logic [31:0] stall_full_cnt;
  logic [31:0] flush_cnt;
  fetch_decode_queue #(.XLEN(32), .DEPTH(4), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .stall_full_cnt(stall_full_cnt), .flush_cnt(flush_cnt)
  );
`else
  fetch_decode_queue #(.XLEN(32), .DEPTH(4), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic        st;
    logic        fl;
    logic [31:0] pc;
    logic        ev;
    logic [31:0] epc;
    logic [2:0]  ecnt;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h00A0_0093 ^ pc;
  endfunction

  function automatic void add(input logic pv, input logic st, input logic fl,
                              input logic [31:0] pc, input logic ev,
                              input logic [31:0] epc, input logic [2:0] ecnt,
                              input logic erdy);
    vec_t v;
    v.pv = pv; v.st = st; v.fl = fl; v.pc = pc;
    v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.erdy = erdy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic ev, input logic [31:0] epc,
                             input logic [2:0] ecnt, input logic erdy);
    chk({tag, " valid_d"},    32'(bus.valid_d),    32'(ev));
    chk({tag, " instr_d"},    bus.instr_d,         ev ? instr_of(epc) : NOP);
    chk({tag, " pc_d"},       bus.pc_d,            ev ? epc : 32'h0);
    chk({tag, " pcplus4_d"},  bus.pcplus4_d,       ev ? epc + 32'd4 : 32'h0);
    chk({tag, " count"},      32'(bus.count),      32'(ecnt));
    chk({tag, " push_ready"}, 32'(bus.push_ready), 32'(erdy));
  endtask

  task automatic drive(input logic pv, input logic st, input logic fl, input logic [31:0] pc);
    bus.push_valid = pv;
    bus.stall_d    = st;
    bus.flush_d    = fl;
    bus.pc_f       = pc;
    bus.pcplus4_f  = pc + 32'd4;
    bus.instr_f    = instr_of(pc);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    bus.instr_f = 32'hDEAD_BEEF;

    // Idle after reset: bubble for five cycles
    for (int i = 0; i < 5; i++) add(0, 0, 0, 32'h0, 0, 32'h0, 3'd0, 1);
    // Single push then bubble
    add(1, 0, 0, 32'h100, 1, 32'h100, 3'd1, 1);
    add(0, 0, 0, 32'h0,   0, 32'h0,   3'd0, 1);
    // Stalled fill; fifth push rejected when full
    add(1, 1, 0, 32'h00, 1, 32'h0, 3'd1, 1);
    add(1, 1, 0, 32'h04, 1, 32'h0, 3'd2, 1);
    add(1, 1, 0, 32'h08, 1, 32'h0, 3'd3, 1);
    add(1, 1, 0, 32'h0C, 1, 32'h0, 3'd4, 0);
    add(1, 1, 0, 32'h10, 1, 32'h0, 3'd4, 0);
    // Release stall and drain in order
    add(0, 0, 0, 32'h0, 1, 32'h04, 3'd3, 1);
    add(0, 0, 0, 32'h0, 1, 32'h08, 3'd2, 1);
    add(0, 0, 0, 32'h0, 1, 32'h0C, 3'd1, 1);
    add(0, 0, 0, 32'h0, 0, 32'h00, 3'd0, 1);
    // Stall on an empty queue does nothing
    add(0, 1, 0, 32'h0, 0, 32'h0, 3'd0, 1);
    // Streaming push+pop across pointer wrap
    for (int i = 0; i < 10; i++)
      add(1, 0, 0, 32'(i * 4), 1, 32'(i * 4), 3'd1, 1);
    add(0, 0, 0, 32'h0, 0, 32'h0, 3'd0, 1);
    // Full queue: pop happens but the same-cycle push is rejected
    add(1, 1, 0, 32'h400, 1, 32'h400, 3'd1, 1);
    add(1, 1, 0, 32'h404, 1, 32'h400, 3'd2, 1);
    add(1, 1, 0, 32'h408, 1, 32'h400, 3'd3, 1);
    add(1, 1, 0, 32'h40C, 1, 32'h400, 3'd4, 0);
    add(1, 0, 0, 32'h410, 1, 32'h404, 3'd3, 1);
    add(1, 0, 0, 32'h410, 1, 32'h408, 3'd3, 1);
    add(0, 0, 0, 32'h0,   1, 32'h40C, 3'd2, 1);
    add(0, 0, 0, 32'h0,   1, 32'h410, 3'd1, 1);
    add(0, 0, 0, 32'h0,   0, 32'h0,   3'd0, 1);
    // Flush with count=3 discards everything including a same-cycle push
    add(1, 1, 0, 32'h300, 1, 32'h300, 3'd1, 1);
    add(1, 1, 0, 32'h304, 1, 32'h300, 3'd2, 1);
    add(1, 1, 0, 32'h308, 1, 32'h300, 3'd3, 1);
    add(1, 0, 1, 32'h200, 0, 32'h0,   3'd0, 1);
    add(0, 0, 0, 32'h0,   0, 32'h0,   3'd0, 1);
    add(0, 0, 0, 32'h0,   0, 32'h0,   3'd0, 1);

    #2;
    chk_outputs("reset", 1'b0, 32'h0, 3'd0, 1'b1);
`ifdef FDQ_PERF_EN
    chk("reset stall_full_cnt", stall_full_cnt, 32'h0);
    chk("reset flush_cnt",      flush_cnt,      32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].pv, vecs[i].st, vecs[i].fl, vecs[i].pc);
      @(posedge clk);
      #1;
      chk_outputs($sformatf("v%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ecnt, vecs[i].erdy);
    end

`ifdef FDQ_PERF_EN
    // One rejected push in the stalled fill, one in the full-queue pop, one flush
    chk("perf stall_full_cnt", stall_full_cnt, 32'd2);
    chk("perf flush_cnt",      flush_cnt,      32'd1);
`endif

    // Async reset mid-cycle with two entries queued
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h500);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h504);
    @(posedge clk);
    #1;
    chk_outputs("pre_reset", 1'b1, 32'h500, 3'd2, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    reset = 1'b1;
    #1;
    chk_outputs("async_reset", 1'b0, 32'h0, 3'd0, 1'b1);
`ifdef FDQ_PERF_EN
    chk("async_reset stall_full_cnt", stall_full_cnt, 32'h0);
    chk("async_reset flush_cnt",      flush_cnt,      32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_outputs("post_reset", 1'b0, 32'h0, 3'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
